addr_fetch: RTL
===============

ADDR_FETCH -- requirements
Module: addr_fetch

Interface
REQ-001 Parameter ADDR_W, default 32, address width; matches the addr stream from the address generator.
REQ-002 Parameter DATA_W, default 32, memory read data width.
REQ-003 Parameter DEPTH, default 4, response buffer entries and maximum reads in flight; power of two, at least 2.
REQ-004 Port clk, input, 1, single clock; all state on rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port start, input, 1, one-cycle pulse that begins a transfer of len elements.
REQ-007 Port len, input, 16, element count, sampled when start is accepted.
REQ-008 Port addr_in / addr_valid / addr_ready, input / input / output, ADDR_W/1/1, upstream address stream.
REQ-009 Port mem_req_addr / mem_req_valid / mem_req_ready, output / output / input, ADDR_W/1/1, memory read request.
REQ-010 Port mem_rsp_data / mem_rsp_valid, input / input, DATA_W/1, in-order read responses with no backpressure.
REQ-011 Port data_out / data_valid / data_ready, output / output / input, DATA_W/1/1, downstream data stream.
REQ-012 Port busy / done / err, output / output / output, 1/1/1, status; done is a one-cycle pulse, err is sticky.

Function
REQ-013 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-014 IDLE with start and len!=0: latch len, clear issued/returned counters and err, go to RUN next cycle.
REQ-015 IDLE with start and len==0: pulse done next cycle; stay in IDLE.
REQ-016 start while not in IDLE is ignored.
REQ-017 Request handshake:
  - Gate g = (state==RUN) and (issued<len) and (credits>0).
  - mem_req_valid = addr_valid and g.
  - addr_ready = mem_req_ready and g.
  - mem_req_addr = addr_in.
  - All three are combinational pass-through, zero latency.
REQ-018 credits = DEPTH - (in-flight + buffer occupancy); a request handshake decrements credits and a data_out handshake increments them, both in the same cycle if simultaneous.
REQ-019 Each mem_rsp_valid in RUN or DRAIN writes mem_rsp_data into the buffer and increments returned; credits guarantee the buffer is never full when a response arrives.
REQ-020 data_valid = buffer not empty; data_out = oldest entry; a pop occurs on data_valid and data_ready.
REQ-021 A simultaneous push and pop leaves occupancy unchanged and preserves order, including at DEPTH-1 occupancy and with the buffer empty (no bypass; first data appears one cycle after the response).
REQ-022 RUN goes to DRAIN on the cycle issued reaches len.
REQ-023 DRAIN goes to DONE when returned==len and the buffer is empty.
REQ-024 DONE asserts done for exactly one cycle, then returns to IDLE.
REQ-025 busy = 1 in RUN, DRAIN and DONE.
REQ-026 mem_rsp_valid in IDLE or DONE, or with returned==len, sets err and the data is dropped; err clears only on an accepted start or on reset.
REQ-027 The issued and returned counters are 16 bits and never wrap; len up to 65535 is supported.

Reset
REQ-028 rst_n low asynchronously forces:
  - state IDLE;
  - busy, done, err, data_valid, mem_req_valid and addr_ready all 0;
  - counters 0, buffer empty, credits DEPTH.
REQ-029 Reset asserted mid-transfer abandons in-flight reads; responses arriving after reset are handled per REQ-026.
REQ-030 Reset release is synchronized by the caller; the block does no resynchronization.

Structure
REQ-031 Package addr_fetch_pkg holds the state enum and default DEPTH/ADDR_W/DATA_W constants.
REQ-032 The response buffer is sub-module fetch_fifo (DEPTH x DATA_W, synchronous push/pop, full/empty/count outputs).
REQ-033 Credit, counter and FSM logic reside in addr_fetch.

Verification
REQ-034 Basic transfer:
  - Stimulus: len=8, addr 0,4,...,28, memory latency 2, data_ready=1.
  - Response: data_out = mem[addr] in order, done 1 cycle after the last pop, busy low afterwards.
REQ-035 Backpressure:
  - Stimulus: len=16, DEPTH=4, data_ready=0 for 20 cycles.
  - Response: exactly 4 requests issued, then mem_req_valid=0; no loss or reorder after data_ready=1.
REQ-036 Zero length:
  - Stimulus: start with len=0.
  - Response: done pulse next cycle, no requests, busy stays 0.
REQ-037 Simultaneous events:
  - Stimulus: random mem_req_ready/data_ready, response pushed in the same cycle as a pop at occupancy 3.
  - Response: ordered stream, count held at 3.
REQ-038 Reset and error:
  - Stimulus: rst_n low with 3 reads in flight, then a spurious mem_rsp_valid.
  - Response: outputs at reset values, err=1, and err cleared by the next start.

Source files
------------

// File: rtl/addr_fetch_pkg.sv
// addr_fetch_pkg: state encoding and default sizes shared by the address-driven fetch engine.
package addr_fetch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 4;
endpackage

// File: rtl/addr_fetch_fifo.sv
// fetch_fifo: in-order response buffer with synchronous push/pop; pointers wrap naturally (DEPTH is a power of two).
module fetch_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        push_data,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic push_ok, pop_ok;
    assign full     = count == (AW+1)'(DEPTH);
    assign empty    = count == '0;
    assign pop_data = mem[rd_ptr];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/addr_fetch.sv
// addr_fetch: turns an address stream into credit-limited memory reads and streams the in-order responses downstream.
module addr_fetch import addr_fetch_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       len,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              addr_valid,
    output logic              addr_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    input  logic [DATA_W-1:0] mem_rsp_data,
    input  logic              mem_rsp_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CW = $clog2(DEPTH) + 1;
    state_t state;
    logic [15:0] len_q, issued, returned;
    logic [CW-1:0] credits, count;
    logic gate, req_hs, pop, rsp_ok, full, empty;
    // Credits cover both in-flight reads and buffered data, so a response always finds room.
    assign gate          = state == RUN && issued < len_q && credits != '0;
    assign mem_req_valid = addr_valid && gate;
    assign addr_ready    = mem_req_ready && gate;
    assign mem_req_addr  = addr_in;
    assign req_hs        = mem_req_valid && mem_req_ready;
    assign data_valid    = !empty;
    assign pop           = data_valid && data_ready;
    assign rsp_ok        = mem_rsp_valid && (state == RUN || state == DRAIN) && returned != len_q && !full;
    fetch_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_buf (
        .clk(clk), .rst_n(rst_n), .push(rsp_ok), .pop(pop), .push_data(mem_rsp_data),
        .pop_data(data_out), .full(full), .empty(empty), .count(count)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            len_q    <= '0;
            issued   <= '0;
            returned <= '0;
            credits  <= CW'(DEPTH);
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done    <= 1'b0;
            credits <= credits + CW'(pop) - CW'(req_hs);
            if (req_hs) issued <= issued + 16'd1;
            if (rsp_ok) returned <= returned + 16'd1;
            if (mem_rsp_valid && !rsp_ok) err <= 1'b1;
            case (state)
                IDLE: if (start && len != '0) begin
                    state    <= RUN;
                    busy     <= 1'b1;
                    len_q    <= len;
                    issued   <= '0;
                    returned <= '0;
                    credits  <= CW'(DEPTH);
                    err      <= 1'b0;
                end else if (start) done <= 1'b1;
                RUN: if (req_hs && issued == len_q - 16'd1) state <= DRAIN;
                // Leave on the pop that empties the buffer so done follows the last beat directly.
                DRAIN: if (returned == len_q && (empty || (count == CW'(1) && pop))) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
